timer_entry_loader: RTL and testbench

//  Keypad-to-timer front end for the microwave timer chain. Collects BCD digits

---
 rtl/timer_entry_loader.sv | 171 +++++++++++++++++
 tb/tb_timer_entry_loader.sv | 383 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/timer_entry_loader.sv
// Keypad-to-timer front end: M:SS BCD entry buffer, one-cycle counter load, cook/pause/done.
// Optional macro TIMER_QUICK_START_EN: start in IDLE loads 0:30 and begins cooking.
module timer_entry_loader #(
  parameter int DIGITS       = 3,
  parameter int SEC_TENS_MAX = 5,
  parameter int DONE_CYCLES  = 8
) (
  input  logic                  clock,
  input  logic                  clear,
  input  logic                  key_valid,
  input  logic [3:0]            key_code,
  input  logic                  start,
  input  logic                  stop_clr,
  input  logic                  door_open,
  input  logic                  counters_zero,
  output logic [4*DIGITS-1:0]   data_out,
  output logic                  loadn,
  output logic                  enable_count,
  output logic                  running,
  output logic                  done
);

  localparam int W  = 4 * DIGITS;
  localparam int CW = $clog2(DONE_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ENTRY,
    S_LOAD,
    S_COOK,
    S_PAUSE,
    S_DONE
  } state_t;

  state_t         state_q, state_d;
  logic [W-1:0]   buf_q, buf_d;
  logic [W-1:0]   data_q, data_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           first_q, first_d;
  logic           loadn_q, loadn_d;
  logic           en_q, en_d;
  logic           run_q, run_d;
  logic           done_q, done_d;

  logic           key_dig;
  logic [W-1:0]   shifted;

  assign key_dig = key_valid && (key_code < 4'd10);
  assign shifted = {buf_q[W-5:0], key_code};

  // Sec-tens digit sits in bits [7:4]; clamp keeps entries like 9:75 valid.
  function automatic logic [W-1:0] clamp(input logic [W-1:0] b);
    logic [W-1:0] r;
    r = b;
    if (b[7:4] > 4'(SEC_TENS_MAX))
      r[7:4] = 4'(SEC_TENS_MAX);
    return r;
  endfunction

  always_comb begin
    state_d = state_q;
    buf_d   = buf_q;
    cnt_d   = cnt_q;
    first_d = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (stop_clr) begin
          buf_d = '0;
        end
`ifdef TIMER_QUICK_START_EN
        else if (start && !door_open && buf_q == '0) begin
          buf_d   = W'(12'h030);
          state_d = S_LOAD;
        end
`endif
        else if (key_dig) begin
          buf_d   = shifted;
          state_d = S_ENTRY;
        end
      end
      S_ENTRY: begin
        if (stop_clr) begin
          buf_d   = '0;
          state_d = S_IDLE;
        end else if (start && !door_open && buf_q != '0) begin
          state_d = S_LOAD;
        end else if (key_dig) begin
          buf_d = shifted;
        end
      end
      S_LOAD: begin
        state_d = S_COOK;
        first_d = 1'b1;
      end
      S_COOK: begin
        // The zero flag is stale right after load/resume, so mask one cycle.
        if (counters_zero && !first_q) begin
          state_d = S_DONE;
          cnt_d   = '0;
        end else if (door_open || stop_clr) begin
          state_d = S_PAUSE;
        end
      end
      S_PAUSE: begin
        if (stop_clr) begin
          buf_d   = '0;
          state_d = S_IDLE;
        end else if (start && !door_open) begin
          state_d = S_COOK;
          first_d = 1'b1;
        end
      end
      S_DONE: begin
        if (stop_clr || cnt_q == CW'(DONE_CYCLES - 1)) begin
          buf_d   = '0;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        buf_d   = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  // Outputs are registered from the next state so they align with it.
  always_comb begin
    data_d = data_q;
    if (state_d == S_LOAD)
      data_d = clamp(buf_d);
    else if (state_d == S_IDLE || state_d == S_ENTRY)
      data_d = buf_d;
    loadn_d = (state_d != S_LOAD);
    en_d    = (state_d == S_COOK);
    run_d   = (state_d == S_COOK);
    done_d  = (state_d == S_DONE);
  end

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      state_q <= S_IDLE;
      buf_q   <= '0;
      data_q  <= '0;
      cnt_q   <= '0;
      first_q <= 1'b0;
      loadn_q <= 1'b1;
      en_q    <= 1'b0;
      run_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      buf_q   <= buf_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      first_q <= first_d;
      loadn_q <= loadn_d;
      en_q    <= en_d;
      run_q   <= run_d;
      done_q  <= done_d;
    end
  end

  assign data_out     = data_q;
  assign loadn        = loadn_q;
  assign enable_count = en_q;
  assign running      = run_q;
  assign done         = done_q;

endmodule

// File: tb/tb_timer_entry_loader.sv
// Self-checking bench for timer_entry_loader: directed scenarios plus
// randomized key entry checked against a digit-list reference model.
module tb_timer_entry_loader;

  localparam int TENS_MAX = 5;

  logic        clock;
  logic        clear;
  logic        key_valid;
  logic [3:0]  key_code;
  logic        start;
  logic        stop_clr;
  logic        door_open;
  logic        counters_zero;
  logic [11:0] data_out;
  logic        loadn;
  logic        enable_count;
  logic        running;
  logic        done;

  int checks;
  int errors;

  timer_entry_loader #(
    .DIGITS(3),
    .SEC_TENS_MAX(5),
    .DONE_CYCLES(8)
  ) dut (
    .clock(clock),
    .clear(clear),
    .key_valid(key_valid),
    .key_code(key_code),
    .start(start),
    .stop_clr(stop_clr),
    .door_open(door_open),
    .counters_zero(counters_zero),
    .data_out(data_out),
    .loadn(loadn),
    .enable_count(enable_count),
    .running(running),
    .done(done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    key_valid     = 1'b0;
    key_code      = 4'd0;
    start         = 1'b0;
    stop_clr      = 1'b0;
    door_open     = 1'b0;
    counters_zero = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    clear = 1'b1;
    #3;
    clear = 1'b0;
    step();
  endtask

  task automatic press(input logic [3:0] k);
    key_valid = 1'b1;
    key_code  = k;
    step();
    key_valid = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    clear = 1'b1;
    #2;
    checks++;
    if (data_out !== 12'h000) begin
      errors++;
      $display("FAIL reset_data got %h want 000", data_out);
    end
    checks++;
    if (loadn !== 1'b1) begin
      errors++;
      $display("FAIL reset_loadn got %b want 1", loadn);
    end
    checks++;
    if ({enable_count, running, done} !== 3'b000) begin
      errors++;
      $display("FAIL reset_flags got %b want 000",
               {enable_count, running, done});
    end
    clear = 1'b0;
    step();
  endtask

  task automatic test_entry_load();
    do_reset();
    press(4'd1);
    checks++;
    if (data_out !== 12'h001) begin
      errors++;
      $display("FAIL entry_first got %h want 001", data_out);
    end
    press(4'd3);
    press(4'd0);
    checks++;
    if (data_out !== 12'h130) begin
      errors++;
      $display("FAIL entry_130 got %h want 130", data_out);
    end
    start = 1'b1;
    step();
    start = 1'b0;
    checks++;
    if (loadn !== 1'b0 || data_out !== 12'h130) begin
      errors++;
      $display("FAIL load_130 got loadn=%b data=%h want 0/130",
               loadn, data_out);
    end
    step();
    checks++;
    if ({loadn, enable_count, running} !== 3'b111) begin
      errors++;
      $display("FAIL cook_entry got %b want 111",
               {loadn, enable_count, running});
    end
  endtask

  task automatic test_shift_clamp();
    do_reset();
    press(4'd9);
    press(4'd8);
    press(4'd7);
    press(4'd6);
    checks++;
    if (data_out !== 12'h876) begin
      errors++;
      $display("FAIL shift_876 got %h want 876", data_out);
    end
    start = 1'b1;
    step();
    start = 1'b0;
    checks++;
    if (loadn !== 1'b0 || data_out !== 12'h856) begin
      errors++;
      $display("FAIL clamp_856 got loadn=%b data=%h want 0/856",
               loadn, data_out);
    end
    step();
    checks++;
    if (enable_count !== 1'b1) begin
      errors++;
      $display("FAIL clamp_cook got %b want 1", enable_count);
    end
  endtask

  task automatic test_pause();
    door_open = 1'b1;
    step();
    checks++;
    if ({enable_count, running} !== 2'b00 || data_out !== 12'h856) begin
      errors++;
      $display("FAIL pause got en=%b run=%b data=%h want 0/0/856",
               enable_count, running, data_out);
    end
    door_open = 1'b0;
    start     = 1'b1;
    step();
    start = 1'b0;
    checks++;
    if ({loadn, enable_count} !== 2'b11) begin
      errors++;
      $display("FAIL resume got loadn=%b en=%b want 1/1",
               loadn, enable_count);
    end
    step();
    checks++;
    if (loadn !== 1'b1 || data_out !== 12'h856) begin
      errors++;
      $display("FAIL resume_noload got loadn=%b data=%h want 1/856",
               loadn, data_out);
    end
  endtask

  task automatic test_done();
    int n;
    do_reset();
    press(4'd2);
    start = 1'b1;
    step();
    start         = 1'b0;
    counters_zero = 1'b1;
    step();
    step();
    checks++;
    if (running !== 1'b1 || done !== 1'b0) begin
      errors++;
      $display("FAIL zero_mask got run=%b done=%b want 1/0",
               running, done);
    end
    step();
    counters_zero = 1'b0;
    checks++;
    if (done !== 1'b1 || enable_count !== 1'b0) begin
      errors++;
      $display("FAIL done_entry got done=%b en=%b want 1/0",
               done, enable_count);
    end
    n = (done === 1'b1) ? 1 : 0;
    while (done === 1'b1 && n < 20) begin
      step();
      if (done === 1'b1) n++;
    end
    checks++;
    if (n != 8) begin
      errors++;
      $display("FAIL done_len got %0d want 8", n);
    end
    checks++;
    if (data_out !== 12'h000 || running !== 1'b0) begin
      errors++;
      $display("FAIL done_idle got data=%h run=%b want 000/0",
               data_out, running);
    end
    press(4'd4);
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    clear = 1'b1;
    #1;
    checks++;
    if ({running, enable_count, loadn} !== 3'b001 ||
        data_out !== 12'h000) begin
      errors++;
      $display("FAIL async_clear got %b data=%h want 001/000",
               {running, enable_count, loadn}, data_out);
    end
    clear = 1'b0;
    step();
  endtask

  task automatic test_stop_clear();
    do_reset();
    press(4'd0);
    press(4'd0);
    press(4'd5);
    checks++;
    if (data_out !== 12'h005) begin
      errors++;
      $display("FAIL entry_005 got %h want 005", data_out);
    end
    stop_clr = 1'b1;
    start    = 1'b1;
    step();
    stop_clr = 1'b0;
    start    = 1'b0;
    checks++;
    if (data_out !== 12'h000 || loadn !== 1'b1) begin
      errors++;
      $display("FAIL stop_wins got data=%h loadn=%b want 000/1",
               data_out, loadn);
    end
    step();
    checks++;
    if (loadn !== 1'b1 || running !== 1'b0) begin
      errors++;
      $display("FAIL stop_noload got loadn=%b run=%b want 1/0",
               loadn, running);
    end
  endtask

  task automatic test_quick_start();
    logic       exp_load;
    logic [11:0] exp_data;
`ifdef TIMER_QUICK_START_EN
    exp_load = 1'b1;
    exp_data = 12'h030;
`else
    exp_load = 1'b0;
    exp_data = 12'h000;
`endif
    do_reset();
    start = 1'b1;
    step();
    start = 1'b0;
    checks++;
    if (loadn !== !exp_load || data_out !== exp_data) begin
      errors++;
      $display("FAIL quick_start got loadn=%b data=%h want %b/%h",
               loadn, data_out, !exp_load, exp_data);
    end
    step();
    checks++;
    if (running !== exp_load) begin
      errors++;
      $display("FAIL quick_run got %b want %b", running, exp_load);
    end
  endtask

  task automatic test_random();
    int digs[3];
    int n;
    int code;
    bit any_digit;
    bit door;
    bit exp_load;
    int exp_val;
    bit quick;
`ifdef TIMER_QUICK_START_EN
    quick = 1'b1;
`else
    quick = 1'b0;
`endif
    for (int it = 0; it < 25; it++) begin
      do_reset();
      digs      = '{0, 0, 0};
      any_digit = 1'b0;
      n         = $urandom_range(0, 6);
      for (int k = 0; k < n; k++) begin
        code = $urandom_range(0, 15);
        press(4'(code));
        if (code <= 9) begin
          any_digit = 1'b1;
          digs[0]   = digs[1];
          digs[1]   = digs[2];
          digs[2]   = code;
        end
      end
      exp_val = digs[0] * 256 + digs[1] * 16 + digs[2];
      checks++;
      if (data_out !== 12'(exp_val)) begin
        errors++;
        $display("FAIL rand_entry it=%0d got %h want %h",
                 it, data_out, exp_val);
      end
      door = ($urandom_range(0, 3) == 0);
      if (any_digit)
        exp_load = (exp_val != 0) && !door;
      else
        exp_load = quick && !door;
      if (!any_digit && exp_load)
        digs = '{0, 3, 0};
      if (digs[1] > TENS_MAX)
        digs[1] = TENS_MAX;
      exp_val   = digs[0] * 256 + digs[1] * 16 + digs[2];
      door_open = door;
      start     = 1'b1;
      step();
      start     = 1'b0;
      door_open = 1'b0;
      checks++;
      if (loadn !== !exp_load ||
          (exp_load && data_out !== 12'(exp_val))) begin
        errors++;
        $display("FAIL rand_load it=%0d got loadn=%b data=%h want %b/%h",
                 it, loadn, data_out, !exp_load, exp_val);
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    clear  = 1'b0;
    idle_inputs();
    test_reset();
    test_entry_load();
    test_shift_clamp();
    test_pause();
    test_done();
    test_stop_clear();
    test_quick_start();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
